// File: rtl/data_mem_responder.sv
// Memory-side responder: a DEPTH x DATA_W array that answers MemRead/MemWrite
// after WAIT_CYCLES wait states, stalling the requester while an access is in flight.
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] MemIn,
  output logic [DATA_W-1:0] MemOut,
  output logic              MemReady,
  output logic              MemStall,
  output logic              ReqErr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;

  logic              req;
  logic              accept;
  logic              enter_resp;
  logic              use_latched;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic              eff_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req = MemRead | MemWrite;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            cnt_next   = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        // <=1 rather than ==1 so a corrupted zero count can never lock the FSM in WAIT
        if (cnt <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MemReady = (state == RESP);
    MemStall = ((state != RESP) && req) || (state == WAIT);
  end

  // With zero wait states the access completes on the accepting edge, so the live inputs are used
  always_comb begin
    use_latched = (state == WAIT);
    eff_addr    = use_latched ? addr_q : Addr;
    eff_data    = use_latched ? data_q : MemIn;
    eff_wr      = use_latched ? wr_q   : MemWrite;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q <= Addr;
      data_q <= MemIn;
      wr_q   <= MemWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      MemOut <= '0;
      ReqErr <= 1'b0;
    end else begin
      ReqErr <= accept & MemRead & MemWrite;
      if (enter_resp && !eff_wr) begin
        MemOut <= mem[eff_addr];
      end
    end
  end

  // Array is never cleared; a write aborted by reset must not land
  always_ff @(posedge clock) begin
    if (reset && enter_resp && eff_wr) begin
      mem[eff_addr] <= eff_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder: three instances with
// WAIT_CYCLES 2, 0 and 3 checked against an array model with transaction-level timing.
module tb_data_mem_responder;

  localparam int NDUT = 3;
  localparam int WAITS [NDUT] = '{2, 0, 3};

  logic       clock;
  logic       reset;
  logic       mem_read  [NDUT];
  logic       mem_write [NDUT];
  logic [7:0] addr      [NDUT];
  logic [7:0] mem_in    [NDUT];
  logic [7:0] mem_out   [NDUT];
  logic       mem_ready [NDUT];
  logic       mem_stall [NDUT];
  logic       req_err   [NDUT];

  logic [7:0] model_mem   [NDUT][256];
  bit         model_valid [NDUT][256];
  logic [7:0] last_read   [NDUT];
  bit         in_resp     [NDUT];

  int checks_total;
  int checks_passed;

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset(reset), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .Addr(addr[0]), .MemIn(mem_in[0]), .MemOut(mem_out[0]), .MemReady(mem_ready[0]),
    .MemStall(mem_stall[0]), .ReqErr(req_err[0]));

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .Addr(addr[1]), .MemIn(mem_in[1]), .MemOut(mem_out[1]), .MemReady(mem_ready[1]),
    .MemStall(mem_stall[1]), .ReqErr(req_err[1]));

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(3)) dut2 (
    .clock(clock), .reset(reset), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
    .Addr(addr[2]), .MemIn(mem_in[2]), .MemOut(mem_out[2]), .MemReady(mem_ready[2]),
    .MemStall(mem_stall[2]), .ReqErr(req_err[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end else begin
      checks_passed++;
    end
  endtask

  // Every stimulus task starts and ends right after a falling edge
  task automatic applyReset();
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      mem_read[k]  = 1'b0;
      mem_write[k] = 1'b0;
      in_resp[k]   = 1'b0;
      last_read[k] = 8'h00;
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input int k, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int lat;
    bit got;
    mem_read[k]  = rd;
    mem_write[k] = wr;
    addr[k]      = a;
    mem_in[k]    = d;
    #1;
    checkOutput($sformatf("stall_accept%0d", k), mem_stall[k], in_resp[k] ? 1'b0 : 1'b1);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) checkOutput($sformatf("reqerr%0d", k), req_err[k], rd && wr);
      if (mem_ready[k]) got = 1'b1;
      else checkOutput($sformatf("stall_wait%0d", k), mem_stall[k], 1'b1);
    end
    checkOutput($sformatf("latency%0d", k), lat, WAITS[k] + 1);
    checkOutput($sformatf("stall_resp%0d", k), mem_stall[k], 1'b0);
    if (wr) begin
      model_mem[k][a]   = d;
      model_valid[k][a] = 1'b1;
      checkOutput($sformatf("out_hold%0d", k), mem_out[k], last_read[k]);
    end else begin
      if (model_valid[k][a]) last_read[k] = model_mem[k][a];
      else last_read[k] = mem_out[k];
      if (model_valid[k][a]) checkOutput($sformatf("rdata%0d", k), mem_out[k], model_mem[k][a]);
    end
    in_resp[k] = 1'b1;
  endtask

  task automatic goIdle(input int k);
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    @(negedge clock);
    checkOutput($sformatf("ready_idle%0d", k), mem_ready[k], 1'b0);
    checkOutput($sformatf("stall_idle%0d", k), mem_stall[k], 1'b0);
    in_resp[k] = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    for (int k = 0; k < NDUT; k++) begin
      addr[k]   = 8'h00;
      mem_in[k] = 8'h00;
      for (int j = 0; j < 256; j++) model_valid[k][j] = 1'b0;
    end

    applyReset();
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("rst_out%0d", k), mem_out[k], 8'h00);
      checkOutput($sformatf("rst_ready%0d", k), mem_ready[k], 1'b0);
      checkOutput($sformatf("rst_stall%0d", k), mem_stall[k], 1'b0);
      checkOutput($sformatf("rst_err%0d", k), req_err[k], 1'b0);
    end

    $display("[TB] W=2 write then back-to-back read");
    applyStimulus(0, 1'b0, 1'b1, 8'h10, 8'hA5);
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00);
    checkOutput("raw_a5", mem_out[0], 8'hA5);
    goIdle(0);

    $display("[TB] W=0 back-to-back reads");
    applyStimulus(1, 1'b0, 1'b1, 8'h01, 8'h11);
    applyStimulus(1, 1'b0, 1'b1, 8'h02, 8'h22);
    goIdle(1);
    applyStimulus(1, 1'b1, 1'b0, 8'h01, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 8'h02, 8'h00);
    checkOutput("w0_rd02", mem_out[1], 8'h22);
    goIdle(1);

    $display("[TB] simultaneous read and write");
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 8'h3C);
    goIdle(0);
    checkOutput("err_pulse", req_err[0], 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 8'h20, 8'h00);
    checkOutput("both_rd20", mem_out[0], 8'h3C);
    goIdle(0);

    $display("[TB] reset during WAIT aborts write");
    applyStimulus(2, 1'b0, 1'b1, 8'h30, 8'h00);
    goIdle(2);
    mem_write[2] = 1'b1;
    addr[2]      = 8'h30;
    mem_in[2]    = 8'h77;
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort_wait_ready", mem_ready[2], 1'b0);
    reset        = 1'b0;
    mem_write[2] = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("abort_rst_ready", mem_ready[2], 1'b0);
    end
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      in_resp[k]   = 1'b0;
      last_read[k] = 8'h00;
    end
    repeat (4) begin
      @(negedge clock);
      checkOutput("abort_post_ready", mem_ready[2], 1'b0);
    end
    checkOutput("abort_out", mem_out[2], 8'h00);
    applyStimulus(2, 1'b1, 1'b0, 8'h30, 8'h00);
    checkOutput("abort_rd30", mem_out[2], 8'h00);
    goIdle(2);

    $display("[TB] random traffic");
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 30; n++) begin
        int op;
        logic [7:0] a;
        logic [7:0] d;
        bit both;
        op   = $urandom_range(0, 2);
        a    = 8'($urandom_range(0, 15));
        d    = 8'($urandom);
        both = ($urandom_range(0, 7) == 0);
        if (op == 0 && model_valid[k][a]) applyStimulus(k, 1'b1, 1'b0, a, 8'h00);
        else applyStimulus(k, both, 1'b1, a, d);
        if ($urandom_range(0, 1) == 0) goIdle(k);
      end
      if (in_resp[k]) goIdle(k);
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
